// File: rtl/note_mixer_if.sv
// Bundle between the note/keyboard front end and the mixer, plus the mixed
// sample going on to the DAC/PWM stage.
interface note_mixer_if #(
    parameter int NUM_NOTES = 36
);
    logic [NUM_NOTES-1:0]    keys;
    logic [NUM_NOTES*16-1:0] notes;
    logic [15:0]             sample_out;
    logic                    sample_valid;
    logic [5:0]              active_count;
    logic                    busy;

    // Producer side: supplies key flags and note levels, observes the sample.
    modport master (
        output keys,
        output notes,
        input  sample_out,
        input  sample_valid,
        input  active_count,
        input  busy
    );

    // Mixer side.
    modport slave (
        input  keys,
        input  notes,
        output sample_out,
        output sample_valid,
        output active_count,
        output busy
    );
endinterface

// File: rtl/note_mixer.sv
// Note mixer: once per audio sample period, snapshots the key flags and note
// levels, serially sums the levels of pressed notes (one note per clock),
// scales the sum by the pressed-key count, saturates, and emits one 16-bit
// sample with a single-cycle valid strobe.
module note_mixer #(
    parameter int NUM_NOTES  = 36,
    parameter int SAMPLE_DIV = 1136
) (
    input  logic              clk,
    input  logic              rst,
    note_mixer_if.slave       bus
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [5:0]       IDX_LAST  = 6'(NUM_NOTES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_SCALE = 2'd2;

    // Divide the key-gated sum by roughly the number of pressed keys (power of
    // two rounding up), then clamp to the positive 16-bit range. Zero keys
    // always yields silence regardless of the accumulator.
    function automatic logic [15:0] scale_sat(input logic [21:0] acc,
                                               input logic [5:0]  cnt);
        logic [21:0] s;
        if (cnt == 6'd0) begin
            s = 22'd0;
        end else if (cnt == 6'd1) begin
            s = acc;
        end else if (cnt == 6'd2) begin
            s = acc >> 1;
        end else if (cnt <= 6'd4) begin
            s = acc >> 2;
        end else if (cnt <= 6'd8) begin
            s = acc >> 3;
        end else if (cnt <= 6'd16) begin
            s = acc >> 4;
        end else begin
            s = acc >> 5;
        end
        if (s > 22'h007FFF) begin
            return 16'h7FFF;
        end else begin
            return s[15:0];
        end
    endfunction

    logic [CNT_W-1:0]           tick_cnt_q;
    logic                       tick_s;

    logic [1:0]                 state_q, state_d;
    logic [5:0]                 idx_q, idx_d;
    logic [21:0]                acc_q, acc_d;
    logic [5:0]                 kcnt_q, kcnt_d;
    logic [NUM_NOTES-1:0]       keys_snap_q, keys_snap_d;
    logic [NUM_NOTES-1:0][15:0] notes_snap_q, notes_snap_d;
    logic [15:0]                sample_q, sample_d;
    logic [5:0]                 active_q, active_d;
    logic                       valid_q, valid_d;

    assign tick_s = (tick_cnt_q == TICK_LAST);

    // Free-running sample-period counter, independent of the mixer state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q <= '0;
        end else if (tick_s) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + CNT_W'(1);
        end
    end

    // Next-state logic for the IDLE -> SCAN (36 notes) -> SCALE sequence.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        kcnt_d       = kcnt_q;
        keys_snap_d  = keys_snap_q;
        notes_snap_d = notes_snap_q;
        sample_d     = sample_q;
        active_d     = active_q;
        valid_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick_s) begin
                    keys_snap_d  = bus.keys;
                    notes_snap_d = bus.notes;
                    acc_d        = 22'd0;
                    kcnt_d       = 6'd0;
                    idx_d        = 6'd0;
                    state_d      = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (keys_snap_q[idx_q]) begin
                    acc_d  = acc_q + {6'd0, notes_snap_q[idx_q]};
                    kcnt_d = kcnt_q + 6'd1;
                end else begin
                    acc_d  = acc_q;
                    kcnt_d = kcnt_q;
                end
                if (idx_q == IDX_LAST) begin
                    state_d = ST_SCALE;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            ST_SCALE: begin
                sample_d = scale_sat(acc_q, kcnt_q);
                active_d = kcnt_q;
                valid_d  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Mixer state, snapshots and registered outputs; reset aborts any mix.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= 6'd0;
            acc_q        <= 22'd0;
            kcnt_q       <= 6'd0;
            keys_snap_q  <= '0;
            notes_snap_q <= '0;
            sample_q     <= 16'd0;
            active_q     <= 6'd0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            kcnt_q       <= kcnt_d;
            keys_snap_q  <= keys_snap_d;
            notes_snap_q <= notes_snap_d;
            sample_q     <= sample_d;
            active_q     <= active_d;
            valid_q      <= valid_d;
        end
    end

    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.active_count = active_q;
    assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: doc/note_mixer.md
Name: note_mixer

Overview:
- Consumes the 36 square-wave note levels produced by the note generator, together with the 36 key-pressed flags from the keyboard scanner.
- Once per audio sample period, snapshots both, then serially sums the levels of the pressed notes over 36 clocks.
- Scales the sum by the number of pressed keys, saturates it, and presents one 16-bit sample with a one-cycle valid strobe to the DAC/PWM stage.

Parameters:
- NUM_NOTES, 36, number of note channels (C1..B3 order, index 0 = C1).
- SAMPLE_DIV, 1136, clock cycles per audio sample (50 MHz / ~44 kHz). Must be >= 40.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- keys  in  36  key-pressed flags; bit i gates note i.
- notes  in  576  flattened note levels; note i occupies bits [16i+15:16i]; each is 0 or the generator ON level.
- sample_out  out  16  mixed, scaled, saturated audio sample.
- sample_valid  out  1  one-cycle pulse when sample_out is updated.
- active_count  out  6  number of pressed keys included in the current sample_out.
- busy  out  1  high while a mix is in progress (SCAN or SCALE).

Behaviour:
- Reset (rst low, asynchronous): sample_out=0, sample_valid=0, active_count=0, busy=0, state IDLE, tick counter=0, accumulator=0, key count=0, index=0, snapshots=0.
- Tick counter: counts 0..SAMPLE_DIV-1 and wraps. tick is asserted combinationally when the counter equals SAMPLE_DIV-1. The counter runs in every state.
- States are IDLE, SCAN and SCALE.
- IDLE, on a tick edge:
  - Register keys and notes into snapshot registers.
  - Clear the accumulator (22 bits, unsigned) and the key count (6 bits).
  - Set index=0 and go to SCAN.
- SCAN, at each edge:
  - If snapshot key[index]=1, add note[index] (zero-extended) to the accumulator and increment the key count.
  - At index=35, go to SCALE; otherwise increment index.
  - Exactly 36 SCAN cycles occur.
- SCALE, one edge:
  - Compute scaled = accumulator >> shift. The shift is chosen from the key count: 0 keys gives result 0; 1 gives 0; 2 gives 1; 3-4 gives 2; 5-8 gives 3; 9-16 gives 4; 17-36 gives 5.
  - Saturate scaled to 16'h7FFF.
  - Register sample_out=scaled, active_count=key count, sample_valid=1. Go to IDLE.
- sample_valid is high for exactly one cycle. It is cleared on the following edge.
- Latency: sample_valid is high in the cycle that begins 37 clock edges after the tick edge.
- sample_out and active_count hold their value between updates.
- busy is high in SCAN and SCALE and low in IDLE.
- Input changes during SCAN or SCALE have no effect on the current sample, because only the snapshot is used.
- A tick arriving while not in IDLE is ignored and no sample is produced for it. This case is unreachable when SAMPLE_DIV >= 40.
- Reset asserted mid-SCAN aborts the mix immediately. No sample_valid is produced. The next mix starts at the first tick after reset is released, i.e. SAMPLE_DIV cycles after release.
- Width rules:
  - The maximum sum is 36 x 16'h3FFF = 589788, which fits in 22 bits.
  - The accumulator never wraps.
  - Saturation is a guard for ON levels above 16'h3FFF.

Test Plan:
1. Reset, then no keys pressed, all notes 16'h3FFF -> sample_valid pulses every 1136 cycles; sample_out=0 and active_count=0.
2. Only key 0 (C1) pressed, note0=16'h3FFF -> sample_out=16'h3FFF, active_count=1. The valid pulse occurs 37 edges after the tick edge.
3. Keys 0 and 9 pressed, note0=16'h3FFF, note9=0 -> sum 16383 >> 1 gives sample_out=16'h1FFF, active_count=2. With both at 16'h3FFF -> sample_out=16'h3FFF.
4. All 36 keys pressed, all notes 16'h3FFF -> sum 589788 >> 5 gives sample_out=16'h47FE, active_count=36. Single key at 16'hFFFF -> sample_out saturates to 16'h7FFF.
5. Key 0 pressed at tick, released and note0 forced to 0 during SCAN -> sample_out still 16'h3FFF. The next sample reflects the new inputs.
6. rst pulsed low mid-SCAN -> all outputs 0 immediately and no sample_valid for that period. The first valid pulse arrives 1136+37 edges after reset release.
